iq_pair_sequencer: RTL
======================

// Module: iq_pair_sequencer
// PURPOSE
//  Parametrised successor to the IQ-demod pair selector. Captures a frame of NUM_PAIRS
//  sample pairs, then emits them as registered (out1,out2) pairs over a valid/ready stream.
//  Two modes: SCAN emits every pair in index order; DIRECT emits the single pair at sel.
//  Sits between the sample front-end and the correlator in iq_demod.
// PARAMETERS
//  W          5   sample width, bits
//  NUM_PAIRS  5   pairs per frame; 2*NUM_PAIRS input samples
//  SEL_W      $clog2(NUM_PAIRS) (min 1)   index width; derived, do not override
// PORTS
//  clk        in   1                  single clock, rising edge
//  rst        in   1                  asynchronous, active-high reset
//  in_data    in   2*NUM_PAIRS*W      sample s at [s*W +: W]; pair k = (sample 2k, sample 2k+1)
//  in_valid   in   1                  frame present
//  in_ready   out  1                  frame accepted when in_valid && in_ready
//  mode       in   1                  0 = DIRECT, 1 = SCAN; sampled only at capture
//  sel        in   SEL_W              DIRECT pair index; sampled only at capture
//  flush      in   1                  synchronous abort; returns to IDLE
//  out1       out  W                  first sample of current pair (registered)
//  out2       out  W                  second sample of current pair (registered)
//  out_idx    out  SEL_W              index of current pair
//  out_last   out  1                  current beat is the last of the frame
//  out_valid  out  1                  output beat present
//  out_ready  in   1                  beat consumed when out_valid && out_ready
//  sel_err    out  1                  one-cycle pulse: DIRECT capture with sel >= NUM_PAIRS
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; out1/out2/out_idx=0; out_last/out_valid/sel_err=0;
//   frame buffer cleared. in_ready=1 once reset releases.
//  FSM states: IDLE, EMIT.
//  IDLE: in_ready=1. On capture edge (in_valid=1):
//   - always load the frame buffer with in_data; later in_data changes have no effect.
//   - SCAN: load pair 0 into out regs, out_idx=0, out_valid=1, out_last=(NUM_PAIRS==1).
//     Go to EMIT.
//   - DIRECT, sel<NUM_PAIRS: load pair sel, out_idx=sel, out_valid=1, out_last=1. Go to EMIT.
//   - DIRECT, sel>=NUM_PAIRS: sel_err=1 for one cycle, no beat, stay in IDLE.
//  Latency: the beat is valid in the cycle after the capture edge.
//  EMIT: in_ready=0. Out regs, out_idx and out_last hold stable while out_valid && !out_ready.
//   - On handshake with out_last=0: load pair idx+1, advance idx. Throughput 1 beat/cycle.
//   - On handshake with out_last=1: out_valid=0, go to IDLE. One idle cycle between frames.
//  flush=1 (any state): next edge out_valid=0, state=IDLE, no sel_err.
//   flush takes priority over capture and handshake in the same cycle.
//   out1/out2 keep their last values (don't-care while out_valid=0).
//  idx never wraps; the last beat always returns the block to IDLE.
//  No latches: every output is fully assigned on every path, including out-of-range sel.
// STRUCTURE
//  iq_demod_pkg: typedef enum logic {MODE_DIRECT, MODE_SCAN} pair_mode_t;
//   typedef enum logic {ST_IDLE, ST_EMIT} pair_seq_state_t.
//  One sub-module, pair_select: combinational buffer[idx] -> (a,b), parametrised by W and
//   NUM_PAIRS, with a defined 0 output for out-of-range idx.
//   Instantiate it once, with its output feeding the out regs.
// TESTING (W=5, NUM_PAIRS=5, sample s = s+1, so pair k = (2k+1, 2k+2))
//  1 rst=1 in the middle of a SCAN frame -> same cycle: out_valid=0, out1=out2=0;
//    after release: in_ready=1.
//  2 SCAN, out_ready=1 -> pairs (1,2),(3,4),(5,6),(7,8),(9,10) on consecutive cycles;
//    out_idx 0..4; out_last only on idx 4; in_ready=1 the cycle after.
//  3 SCAN, out_ready=0 for 3 cycles at idx 2 -> (5,6) idx 2 held; no beat skipped or
//    repeated; in_data changed after capture has no effect.
//  4 DIRECT sel=3 -> single beat (7,8), out_idx=3, out_last=1, then IDLE.
//  5 DIRECT sel=5 -> sel_err=1 for exactly one cycle; out_valid stays 0; in_ready stays 1.
//  6 flush asserted at idx 2 together with out_ready=1 -> out_valid=0 next cycle,
//    state IDLE; a new frame is then accepted normally.

Source files
------------

// File: rtl/iq_demod_pkg.sv
// Shared types for the iq_demod datapath.
// Mode and sequencer state encodings.
package iq_demod_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } pair_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } pair_seq_state_t;

endpackage

// File: rtl/iq_pair_sequencer_pair_select.sv
// Combinational pair picker: frame[idx] -> (a, b).
// Out-of-range idx yields zeros.
module pair_select #(
  parameter  int W         = 5,
  parameter  int NUM_PAIRS = 5,
  localparam int SEL_W     = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
) (
  input  logic [2*NUM_PAIRS*W-1:0] frame,
  input  logic [SEL_W-1:0]         idx,
  output logic [W-1:0]             a,
  output logic [W-1:0]             b
);

  always_comb begin
    a = '0;
    b = '0;
    for (int k = 0; k < NUM_PAIRS; k++) begin
      if (idx == SEL_W'(k)) begin
        a = frame[2*k*W +: W];
        b = frame[(2*k+1)*W +: W];
      end
    end
  end

endmodule

// File: rtl/iq_pair_sequencer.sv
// Frame capture + pair emitter for iq_demod.
// SCAN streams every pair; DIRECT streams one.
module iq_pair_sequencer
  import iq_demod_pkg::*;
#(
  parameter  int W         = 5,
  parameter  int NUM_PAIRS = 5,
  localparam int SEL_W     = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2*NUM_PAIRS*W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     flush,
  output logic [W-1:0]             out1,
  output logic [W-1:0]             out2,
  output logic [SEL_W-1:0]         out_idx,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sel_err
);

  localparam int FW = 2*NUM_PAIRS*W;
  localparam logic [SEL_W:0] NP =
    (SEL_W+1)'(NUM_PAIRS);
  localparam logic [SEL_W-1:0] LAST_IDX =
    SEL_W'(NUM_PAIRS - 1);

  pair_seq_state_t  state_q, state_d;
  logic [FW-1:0]    frame_q, frame_d;
  logic [W-1:0]     out1_q, out1_d;
  logic [W-1:0]     out2_q, out2_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;
  logic             sel_err_q, sel_err_d;

  logic [FW-1:0]    pick_frame;
  logic [SEL_W-1:0] pick_idx;
  logic [SEL_W-1:0] idx_nxt;
  logic [W-1:0]     pick_a, pick_b;
  logic             is_scan;

  assign idx_nxt = idx_q + SEL_W'(1);
  assign is_scan = (pair_mode_t'(mode) == MODE_SCAN);

  // In IDLE the buffer is not loaded yet, so pick from in_data.
  pair_select #(
    .W         (W),
    .NUM_PAIRS (NUM_PAIRS)
  ) u_pick (
    .frame (pick_frame),
    .idx   (pick_idx),
    .a     (pick_a),
    .b     (pick_b)
  );

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    out1_d     = out1_q;
    out2_d     = out2_q;
    idx_d      = idx_q;
    last_d     = last_q;
    valid_d    = valid_q;
    sel_err_d  = 1'b0;
    pick_frame = frame_q;
    pick_idx   = idx_nxt;
    if (flush) begin
      valid_d = 1'b0;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          pick_frame = in_data;
          pick_idx   = is_scan ? '0 : sel;
          if (in_valid) begin
            frame_d = in_data;
            if (is_scan) begin
              out1_d  = pick_a;
              out2_d  = pick_b;
              idx_d   = '0;
              last_d  = (NUM_PAIRS == 1);
              valid_d = 1'b1;
              state_d = ST_EMIT;
            end else if ({1'b0, sel} < NP) begin
              out1_d  = pick_a;
              out2_d  = pick_b;
              idx_d   = sel;
              last_d  = 1'b1;
              valid_d = 1'b1;
              state_d = ST_EMIT;
            end else begin
              sel_err_d = 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (valid_q && out_ready) begin
            if (last_q) begin
              valid_d = 1'b0;
              state_d = ST_IDLE;
            end else begin
              out1_d = pick_a;
              out2_d = pick_b;
              idx_d  = idx_nxt;
              last_d = (idx_nxt == LAST_IDX);
            end
          end
        end
        default: begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      out1_q    <= '0;
      out2_q    <= '0;
      idx_q     <= '0;
      last_q    <= 1'b0;
      valid_q   <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      out1_q    <= out1_d;
      out2_q    <= out2_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out1      = out1_q;
  assign out2      = out2_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;
  assign sel_err   = sel_err_q;

endmodule
